servo_cmd_ctrl: RTL and testbench

Command sequencer for the hobby-servo PWM channel. Accepts 8-bit position commands over a valid/ready handshake and maps each to a pulse width between 1 ms and 2 ms. It slews the duty toward that target at a bounded rate, changing it only on PWM frame boundaries, and falls back to a neutral (1.5 ms) position when commands stop arriving. Outputs `duty_cycle` and `period` to drive the existing `PWM` block directly, replacing the fixed 5 s min/max toggling.

---
 rtl/servo_cmd_ctrl_if.sv | 10 +
 rtl/servo_cmd_ctrl.sv | 123 ++++++++++++
 tb/tb_servo_cmd_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/servo_cmd_ctrl_if.sv
// Position-command handshake between a command source and servo_cmd_ctrl.
// One 8-bit position per cmd_valid && cmd_ready transfer.
interface servo_cmd_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_pos;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_pos, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_pos, output cmd_ready);
endinterface

// File: rtl/servo_cmd_ctrl.sv
// Servo command sequencer: maps 8-bit positions to 1-2 ms pulse widths and slews duty once per frame.
// Single-entry command register; cmd_ready drops while a command waits for the next frame boundary.
module servo_cmd_ctrl #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned PERIOD         = 500_000,
  parameter int unsigned STEP           = 500,
  parameter int unsigned TIMEOUT_FRAMES = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  servo_cmd_ctrl_if.slave     cmd,
  output logic [31:0]         duty_cycle,
  output logic [31:0]         period,
  output logic                frame_tick,
  output logic                at_target,
  output logic [1:0]          state
);

  localparam logic [31:0] P32      = 32'(PERIOD);
  localparam logic [31:0] STEP32   = 32'(STEP);
  localparam logic [31:0] DUTY_MIN = P32 / 32'd20;
  localparam logic [31:0] DUTY_MAX = P32 / 32'd10;
  localparam logic [31:0] SPAN     = DUTY_MAX - DUTY_MIN;
  localparam logic [31:0] NEUTRAL  = DUTY_MIN + SPAN / 32'd2;
  localparam int          IW       = (TIMEOUT_FRAMES < 1) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [IW-1:0] TO     = IW'(TIMEOUT_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TRACK    = 2'd1,
    S_FAILSAFE = 2'd2
  } state_e;

  logic [31:0]   fcnt_q, fcnt_d;
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   pend_tgt_q, pend_tgt_d;
  logic [31:0]   target_q, target_d;
  logic [31:0]   duty_q, duty_d;
  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;

  logic [39:0]   prod;
  logic [31:0]   cmd_target;
  logic [31:0]   diff;
  logic [IW-1:0] idle_inc;
  logic          tick;
  logic          xfer;

  always_comb begin
    prod       = 40'(cmd.cmd_pos) * 40'(SPAN);
    cmd_target = DUTY_MIN + 32'(prod / 40'd255);
    tick       = (fcnt_q == P32 - 32'd1);
    xfer       = cmd.cmd_valid && !pend_vld_q;
    idle_inc   = idle_q + IW'(1);
    diff       = '0;

    fcnt_d     = tick ? 32'd0 : fcnt_q + 32'd1;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    target_d   = target_q;
    duty_d     = duty_q;
    state_d    = state_q;
    idle_d     = idle_q;

    // A transfer on the tick cycle only fills the register; it is applied next frame.
    if (xfer) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = cmd_target;
    end

    if (tick) begin
      if (pend_vld_q) begin
        target_d   = pend_tgt_q;
        pend_vld_d = 1'b0;
        idle_d     = '0;
        state_d    = S_TRACK;
      end else if (state_q == S_TRACK) begin
        idle_d = idle_inc;
        if (idle_inc == TO) begin
          state_d  = S_FAILSAFE;
          target_d = NEUTRAL;
        end
      end

      diff = (target_d >= duty_q) ? (target_d - duty_q) : (duty_q - target_d);
      if (STEP32 == 32'd0 || diff <= STEP32) begin
        duty_d = target_d;
      end else if (target_d > duty_q) begin
        duty_d = duty_q + STEP32;
      end else begin
        duty_d = duty_q - STEP32;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      target_q   <= NEUTRAL;
      duty_q     <= NEUTRAL;
      state_q    <= S_IDLE;
      idle_q     <= '0;
    end else begin
      fcnt_q     <= fcnt_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
      state_q    <= state_d;
      idle_q     <= idle_d;
    end
  end

  assign cmd.cmd_ready = !pend_vld_q;
  assign duty_cycle    = duty_q;
  assign period        = P32;
  assign frame_tick    = tick;
  assign at_target     = (duty_q == target_q);
  assign state         = 2'(state_q);

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Randomized bench for servo_cmd_ctrl with a frame-level reference model and a tick-driven scoreboard.
module tb_servo_cmd_ctrl;
  localparam int P   = 1000;
  localparam int ST  = 10;
  localparam int TO  = 4;
  localparam int MIN = P / 20;
  localparam int MAX = P / 10;
  localparam int NEU = MIN + (MAX - MIN) / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  servo_cmd_ctrl_if cif();
  logic [31:0] duty_cycle, period;
  logic        frame_tick, at_target;
  logic [1:0]  state;

  servo_cmd_ctrl #(
    .CLK_FREQ(25_000_000), .PERIOD(P), .STEP(ST), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif),
    .duty_cycle(duty_cycle), .period(period), .frame_tick(frame_tick),
    .at_target(at_target), .state(state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position -> pulse width, one pending slot, per-frame rules.
  typedef struct {
    int duty;
    int st;
    int tgt;
  } exp_t;
  exp_t expq[$];
  int   pendq[$];
  int   m_cnt  = 0;
  int   m_duty = NEU;
  int   m_tgt  = NEU;
  int   m_st   = 0;
  int   m_idle = 0;
  bit   m_tick;
  bit   m_xfer;

  function automatic int map_pos(input int p);
    return MIN + (p * (MAX - MIN)) / 255;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_duty = NEU; m_tgt = NEU; m_st = 0; m_idle = 0;
      pendq.delete();
      expq.delete();
    end else begin
      m_tick = (m_cnt == P - 1);
      m_xfer = cif.cmd_valid && (pendq.size() == 0);
      if (m_tick) begin
        if (pendq.size() != 0) begin
          m_tgt  = pendq.pop_front();
          m_idle = 0;
          m_st   = 1;
        end else if (m_st == 1) begin
          m_idle++;
          if (m_idle == TO) begin
            m_st  = 2;
            m_tgt = NEU;
          end
        end
        if ((m_tgt - m_duty <= ST) && (m_duty - m_tgt <= ST)) m_duty = m_tgt;
        else if (m_tgt > m_duty) m_duty = m_duty + ST;
        else m_duty = m_duty - ST;
        expq.push_back('{m_duty, m_st, m_tgt});
      end
      if (m_xfer) pendq.push_back(map_pos(int'(cif.cmd_pos)));
      m_cnt = m_tick ? 0 : m_cnt + 1;
    end
  end

  // Monitor: per-cycle handshake/tick checks, frame results checked the cycle after each tick.
  bit   post_tick = 1'b0;
  exp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        post_tick = 1'b0;
      end else begin
        if (post_tick) begin
          post_tick = 1'b0;
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: DUT frame with no expected entry at %0t", $time);
          end else begin
            e = expq.pop_front();
            check("duty_cycle", duty_cycle, e.duty);
            check("state", {30'd0, state}, e.st);
            check("at_target", {31'd0, at_target}, (e.duty == e.tgt) ? 1 : 0);
          end
        end
        check("frame_tick", {31'd0, frame_tick}, (m_cnt == P - 1) ? 1 : 0);
        check("cmd_ready", {31'd0, cif.cmd_ready}, (pendq.size() == 0) ? 1 : 0);
        if (frame_tick) post_tick = 1'b1;
      end
    end
  end

  // Stimulus tasks are entered and left on a falling edge.
  task automatic idle(input int n);
    cif.cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int p);
    int n = 0;
    cif.cmd_valid = 1'b1;
    cif.cmd_pos   = 8'(p);
    while (!cif.cmd_ready && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", {31'd0, cif.cmd_ready}, 1);
    @(negedge clk);
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!frame_tick && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("tick_seen", {31'd0, frame_tick}, 1);
  endtask

  initial begin
    int r;
    cif.cmd_valid = 1'b0;
    cif.cmd_pos   = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_duty", duty_cycle, NEU);
    check("rst_state", {30'd0, state}, 0);
    check("rst_ready", {31'd0, cif.cmd_ready}, 1);
    check("rst_at_target", {31'd0, at_target}, 1);
    check("rst_frame_tick", {31'd0, frame_tick}, 0);
    check("period", period, P);
    #2 rst_n = 1'b1;

    idle(3 * P);
    idle(200);
    send(255);  idle(3 * P);
    send(128);  idle(2 * P);
    send(0);    idle(6 * P);
    send(200);  send(30);   idle(3 * P);
    idle(8 * P);
    send(255);  idle(2 * P);
    wait_tick();
    send(100);  idle(3 * P);
    check("period_run", period, P);

    for (int i = 0; i < 18; i++) begin
      r = $urandom_range(0, 9);
      send(r == 0 ? 0 : r == 1 ? 255 : $urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 1200));
    end
    idle(2 * P);

    // Reset mid-slew with a command waiting.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    idle(300);
    send(255);
    wait_tick();
    idle(300);
    send(0);
    idle(200);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_duty", duty_cycle, NEU);
    check("midrst_ready", {31'd0, cif.cmd_ready}, 1);
    check("midrst_state", {30'd0, state}, 0);
    check("midrst_at_target", {31'd0, at_target}, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3 * P + 10);
    check("post_rst_duty", duty_cycle, NEU);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
